// File: rtl/generator_rr_scheduler_if.sv
// generator_rr_scheduler_if
//   Bundles the client request/response port and the generator-facing port of
//   the round-robin generator scheduler.
//   master : the scheduler's view (accepts requests, drives responses and the
//            generator control/argument lines).
//   slave  : the environment's view (clients plus the generator instance).
//   req_*  : per-requester packed request lanes, slice [i*WIDTH +: WIDTH]
//   resp_* : tagged response beats, one per yielded output pair
//   gen_*  : generator start/reset/arguments and its output/valid/done
interface generator_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a, req_b, req_c, req_d;

    logic                     resp_valid;
    logic [ID_W-1:0]          resp_id;
    logic [WIDTH-1:0]         resp_out0, resp_out1;
    logic                     resp_last;
    logic                     resp_timeout;
    logic                     busy;

    logic                     gen_start;
    logic                     gen_reset;
    logic [WIDTH-1:0]         gen_a, gen_b, gen_c, gen_d;
    logic [WIDTH-1:0]         gen_out0, gen_out1;
    logic                     gen_valid;
    logic                     gen_done;

    modport master (
        input  req_valid, req_a, req_b, req_c, req_d,
        input  gen_out0, gen_out1, gen_valid, gen_done,
        output req_ready,
        output resp_valid, resp_id, resp_out0, resp_out1, resp_last, resp_timeout, busy,
        output gen_start, gen_reset, gen_a, gen_b, gen_c, gen_d
    );

    modport slave (
        output req_valid, req_a, req_b, req_c, req_d,
        output gen_out0, gen_out1, gen_valid, gen_done,
        input  req_ready,
        input  resp_valid, resp_id, resp_out0, resp_out1, resp_last, resp_timeout, busy,
        input  gen_start, gen_reset, gen_a, gen_b, gen_c, gen_d
    );
endinterface

// File: rtl/generator_rr_scheduler.sv
// generator_rr_scheduler
//   Time-shares one generator among NUM_REQ requesters. In IDLE a round-robin
//   scan picks a requester, its four arguments are latched and held on gen_a..d,
//   gen_start pulses in LAUNCH, and every gen_valid in RUN becomes a response
//   beat one cycle later tagged with the owner id. The job ends on gen_done
//   (resp_last) or after TIMEOUT RUN cycles (ABORT: gen_reset pulse, then a
//   resp_last+resp_timeout beat).
//   Ports: _clock, _reset (sync, active high), bus (generator_rr_scheduler_if.master)
module generator_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic                     _clock,
    input  logic                     _reset,
    generator_rr_scheduler_if.master bus
);
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, ABORT} state_t;

    state_t               state, state_nxt;
    logic [ID_W-1:0]      rr_ptr, id, id_inc;
    logic [ID_W-1:0]      grant_id;
    logic [ID_W:0]        sum;
    logic                 grant_found;
    logic [NUM_REQ-1:0]   rot;
    logic [CNT_W-1:0]     cnt;
    logic                 timeout_hit;
    logic [WIDTH-1:0]     a_q, b_q, c_q, d_q;
    logic                 resp_valid_q, resp_last_q, resp_to_q;
    logic [ID_W-1:0]      resp_id_q;
    logic [WIDTH-1:0]     out0_q, out1_q;

    // Rotate requests so bit 0 is the requester at rr_ptr; first set bit wins.
    assign rot = (bus.req_valid >> rr_ptr) | (bus.req_valid << (NUM_REQ - int'(rr_ptr)));

    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        sum         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && rot[k]) begin
                grant_found = 1'b1;
                sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
                if (sum >= (ID_W+1)'(NUM_REQ))
                    sum = sum - (ID_W+1)'(NUM_REQ);
                grant_id = sum[ID_W-1:0];
            end
        end
    end

    assign id_inc      = (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
    // cnt counts completed RUN cycles; the TIMEOUT-th one hands over to ABORT.
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TO_LAST));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_found) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = RUN;
            RUN:     if (bus.gen_done) state_nxt = IDLE;       // done beats timeout
                     else if (timeout_hit) state_nxt = ABORT;
            ABORT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge _clock) begin
        if (_reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            id           <= '0;
            cnt          <= '0;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            d_q          <= '0;
            resp_valid_q <= 1'b0;
            resp_last_q  <= 1'b0;
            resp_to_q    <= 1'b0;
            resp_id_q    <= '0;
            out0_q       <= '0;
            out1_q       <= '0;
        end else begin
            state        <= state_nxt;
            resp_valid_q <= 1'b0;
            resp_last_q  <= 1'b0;
            resp_to_q    <= 1'b0;
            out0_q       <= '0;
            out1_q       <= '0;
            case (state)
                IDLE: if (grant_found) begin
                    id  <= grant_id;
                    a_q <= bus.req_a[grant_id*WIDTH +: WIDTH];
                    b_q <= bus.req_b[grant_id*WIDTH +: WIDTH];
                    c_q <= bus.req_c[grant_id*WIDTH +: WIDTH];
                    d_q <= bus.req_d[grant_id*WIDTH +: WIDTH];
                end
                LAUNCH: cnt <= '0;
                RUN: begin
                    // A done without valid still produces a zero-data last beat.
                    if (bus.gen_valid || bus.gen_done) begin
                        resp_valid_q <= 1'b1;
                        resp_id_q    <= id;
                    end
                    if (bus.gen_valid) begin
                        out0_q <= bus.gen_out0;
                        out1_q <= bus.gen_out1;
                    end
                    if (bus.gen_done) begin
                        resp_last_q <= 1'b1;
                        rr_ptr      <= id_inc;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ABORT: begin
                    resp_valid_q <= 1'b1;
                    resp_last_q  <= 1'b1;
                    resp_to_q    <= 1'b1;
                    resp_id_q    <= id;
                    rr_ptr       <= id_inc;
                end
                default: ;
            endcase
        end
    end

    // Grant is suppressed while in reset so no requester sees a phantom accept.
    assign bus.req_ready    = (state == IDLE && grant_found && !_reset)
                              ? (NUM_REQ'(1) << grant_id) : '0;
    assign bus.gen_start    = (state == LAUNCH);
    assign bus.gen_reset    = _reset | (state == ABORT);
    assign bus.busy         = (state != IDLE);
    assign bus.gen_a        = a_q;
    assign bus.gen_b        = b_q;
    assign bus.gen_c        = c_q;
    assign bus.gen_d        = d_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_last    = resp_last_q;
    assign bus.resp_timeout = resp_to_q;
    assign bus.resp_id      = resp_id_q;
    assign bus.resp_out0    = out0_q;
    assign bus.resp_out1    = out1_q;
endmodule

// File: tb/tb_generator_rr_scheduler.sv
// tb_generator_rr_scheduler
//   Directed bench for generator_rr_scheduler (NUM_REQ=4, WIDTH=32, TIMEOUT=10).
//   The bench plays both the clients and the generator. Inputs change and
//   outputs are sampled 1ns after each rising edge.
module tb_generator_rr_scheduler;
    localparam int NR = 4;
    localparam int W  = 32;
    localparam int TO = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    generator_rr_scheduler_if #(.NUM_REQ(NR), .WIDTH(W)) bus();

    generator_rr_scheduler #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT(TO)) dut (
        ._clock (clk),
        ._reset (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_a = '0; bus.req_b = '0; bus.req_c = '0; bus.req_d = '0;
        bus.gen_out0 = '0; bus.gen_out1 = '0; bus.gen_valid = 1'b0; bus.gen_done = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({bus.resp_valid, bus.resp_last, bus.resp_timeout, bus.busy, bus.gen_start, bus.gen_reset} !== 6'b000001) begin
            n_bad++; $display("FAIL reset_flags: got %b want 000001",
                {bus.resp_valid, bus.resp_last, bus.resp_timeout, bus.busy, bus.gen_start, bus.gen_reset});
        end
        n_cmp++;
        if ((bus.gen_a | bus.gen_b | bus.gen_c | bus.gen_d | bus.resp_out0 | bus.resp_out1) !== 32'h0) begin
            n_bad++; $display("FAIL reset_data: got nonzero %h want 0", bus.gen_a | bus.resp_out0);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.gen_reset !== 1'b0) begin
            n_bad++; $display("FAIL reset_release_gen_reset: got %b want 0", bus.gen_reset);
        end
    endtask

    task automatic test_single_job();
        bus.req_a[0 +: W] = 32'd1; bus.req_b[0 +: W] = 32'd2;
        bus.req_c[0 +: W] = 32'd3; bus.req_d[0 +: W] = 32'd4;
        bus.req_valid = 4'b0001;
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0001) begin
            n_bad++; $display("FAIL single_ready: got %b want 0001", bus.req_ready);
        end
        tick();
        bus.req_valid = '0;
        n_cmp++;
        if ({bus.gen_start, bus.busy, bus.req_ready} !== 6'b110000) begin
            n_bad++; $display("FAIL single_launch: got %b want 110000", {bus.gen_start, bus.busy, bus.req_ready});
        end
        n_cmp++;
        if ({bus.gen_a, bus.gen_b, bus.gen_c, bus.gen_d} !== {32'd1, 32'd2, 32'd3, 32'd4}) begin
            n_bad++; $display("FAIL single_args: got %h %h %h %h want 1 2 3 4", bus.gen_a, bus.gen_b, bus.gen_c, bus.gen_d);
        end
        tick();
        n_cmp++;
        if (bus.gen_start !== 1'b0) begin
            n_bad++; $display("FAIL single_start_once: got %b want 0", bus.gen_start);
        end
        bus.gen_valid = 1'b1; bus.gen_out0 = 32'd1; bus.gen_out1 = 32'd2;
        tick();
        n_cmp++;
        if ({bus.resp_valid, bus.resp_last, bus.resp_timeout, bus.resp_id, bus.resp_out0, bus.resp_out1}
            !== {3'b100, 2'd0, 32'd1, 32'd2}) begin
            n_bad++; $display("FAIL single_beat0: got v%b l%b id%0d %0d,%0d want v1 l0 id0 1,2",
                bus.resp_valid, bus.resp_last, bus.resp_id, bus.resp_out0, bus.resp_out1);
        end
        bus.gen_out0 = 32'd3; bus.gen_out1 = 32'd4;
        tick();
        n_cmp++;
        if ({bus.resp_valid, bus.resp_last, bus.resp_id, bus.resp_out0, bus.resp_out1}
            !== {2'b10, 2'd0, 32'd3, 32'd4}) begin
            n_bad++; $display("FAIL single_beat1: got v%b l%b id%0d %0d,%0d want v1 l0 id0 3,4",
                bus.resp_valid, bus.resp_last, bus.resp_id, bus.resp_out0, bus.resp_out1);
        end
        n_cmp++;
        if (bus.gen_a !== 32'd1) begin
            n_bad++; $display("FAIL single_arg_hold: got %0d want 1", bus.gen_a);
        end
        bus.gen_valid = 1'b0; bus.gen_done = 1'b1;
        tick();
        bus.gen_done = 1'b0;
        n_cmp++;
        if ({bus.resp_valid, bus.resp_last, bus.resp_timeout, bus.resp_out0, bus.resp_out1, bus.busy}
            !== {3'b110, 32'd0, 32'd0, 1'b0}) begin
            n_bad++; $display("FAIL single_last: got v%b l%b t%b %0d,%0d busy%b want v1 l1 t0 0,0 busy0",
                bus.resp_valid, bus.resp_last, bus.resp_timeout, bus.resp_out0, bus.resp_out1, bus.busy);
        end
        tick();
        n_cmp++;
        if (bus.resp_valid !== 1'b0) begin
            n_bad++; $display("FAIL single_quiet: got %b want 0", bus.resp_valid);
        end
    endtask

    // rr pointer is 1 after the single job, so requester 2 alone is granted.
    task automatic test_coincident_done();
        bus.req_valid = 4'b0100;
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0100) begin
            n_bad++; $display("FAIL coin_ready: got %b want 0100", bus.req_ready);
        end
        tick(); bus.req_valid = '0;
        tick();
        bus.gen_valid = 1'b1; bus.gen_done = 1'b1;
        bus.gen_out0 = 32'd7; bus.gen_out1 = 32'hFFFF_FFF8;
        tick();
        bus.gen_valid = 1'b0; bus.gen_done = 1'b0;
        n_cmp++;
        if ({bus.resp_valid, bus.resp_last, bus.resp_timeout, bus.resp_id, bus.resp_out0, bus.resp_out1}
            !== {3'b110, 2'd2, 32'd7, 32'hFFFF_FFF8}) begin
            n_bad++; $display("FAIL coin_beat: got v%b l%b id%0d %0d,%0d want v1 l1 id2 7,-8",
                bus.resp_valid, bus.resp_last, bus.resp_id, $signed(bus.resp_out0), $signed(bus.resp_out1));
        end
        tick();
        n_cmp++;
        if ({bus.resp_valid, bus.busy} !== 2'b00) begin
            n_bad++; $display("FAIL coin_no_extra: got v%b busy%b want v0 busy0", bus.resp_valid, bus.busy);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_rdy;
        rst = 1'b1; tick(); rst = 1'b0;
        bus.req_valid = 4'b1111;
        #1;
        for (int j = 0; j < 5; j++) begin
            exp_rdy = 4'b0001 << (j % 4);
            n_cmp++;
            if (bus.req_ready !== exp_rdy) begin
                n_bad++; $display("FAIL fair_grant%0d: got %b want %b", j, bus.req_ready, exp_rdy);
            end
            tick(); tick();
            bus.gen_valid = 1'b1; bus.gen_out0 = 32'(100 + j); bus.gen_out1 = 32'(j);
            tick();
            bus.gen_valid = 1'b0; bus.gen_done = 1'b1;
            n_cmp++;
            if ({bus.resp_valid, bus.resp_id, bus.resp_out0} !== {1'b1, 2'(j % 4), 32'(100 + j)}) begin
                n_bad++; $display("FAIL fair_beat%0d: got v%b id%0d %0d want v1 id%0d %0d",
                    j, bus.resp_valid, bus.resp_id, bus.resp_out0, j % 4, 100 + j);
            end
            tick();
            bus.gen_done = 1'b0;
            n_cmp++;
            if ({bus.resp_valid, bus.resp_last} !== 2'b11) begin
                n_bad++; $display("FAIL fair_last%0d: got %b want 11", j, {bus.resp_valid, bus.resp_last});
            end
        end
        bus.req_valid = '0;
        tick();
    endtask

    // rr pointer is 1 here; a job for requester 3 wraps it to 0.
    task automatic test_wrap();
        bus.req_valid = 4'b1000;
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b1000) begin
            n_bad++; $display("FAIL wrap_ready3: got %b want 1000", bus.req_ready);
        end
        tick(); bus.req_valid = '0;
        tick(); bus.gen_done = 1'b1;
        tick(); bus.gen_done = 1'b0;
        bus.req_valid = 4'b0110;
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0010) begin
            n_bad++; $display("FAIL wrap_ready1: got %b want 0010", bus.req_ready);
        end
        tick(); bus.req_valid = 4'b0100;
        tick(); bus.gen_done = 1'b1;
        tick(); bus.gen_done = 1'b0;
        n_cmp++;
        if (bus.req_ready !== 4'b0100) begin
            n_bad++; $display("FAIL wrap_ready2: got %b want 0100", bus.req_ready);
        end
        tick(); bus.req_valid = '0;
        tick(); bus.gen_done = 1'b1;
        tick(); bus.gen_done = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        int early;
        rst = 1'b1; tick(); rst = 1'b0;
        bus.req_valid = 4'b0110;
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0010) begin
            n_bad++; $display("FAIL to_ready1: got %b want 0010", bus.req_ready);
        end
        tick();
        bus.req_valid = 4'b0100;
        n = 0; early = 0;
        while (n < 40 && bus.gen_reset !== 1'b1) begin
            tick();
            n++;
            if (bus.resp_valid === 1'b1) early++;
        end
        n_cmp++;
        if (n !== TO + 1) begin
            n_bad++; $display("FAIL to_latency: got %0d want %0d cycles to gen_reset", n, TO + 1);
        end
        n_cmp++;
        if (early !== 0) begin
            n_bad++; $display("FAIL to_early_beat: got %0d want 0 beats before abort", early);
        end
        tick();
        n_cmp++;
        if ({bus.resp_valid, bus.resp_last, bus.resp_timeout, bus.resp_id, bus.resp_out0, bus.gen_reset}
            !== {3'b111, 2'd1, 32'd0, 1'b0}) begin
            n_bad++; $display("FAIL to_beat: got v%b l%b t%b id%0d %0d greset%b want v1 l1 t1 id1 0 greset0",
                bus.resp_valid, bus.resp_last, bus.resp_timeout, bus.resp_id, bus.resp_out0, bus.gen_reset);
        end
        n_cmp++;
        if (bus.req_ready !== 4'b0100) begin
            n_bad++; $display("FAIL to_next_grant: got %b want 0100", bus.req_ready);
        end
    endtask

    // Continues from the pending grant of requester 2 left by test_timeout.
    task automatic test_reset_mid_job();
        tick(); bus.req_valid = '0;
        tick();
        bus.gen_valid = 1'b1; bus.gen_out0 = 32'd5; bus.gen_out1 = 32'd6;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            bus.req_valid = 4'b1001;
            #1;
            n_cmp++;
            if ({bus.resp_valid, bus.resp_last, bus.busy, bus.gen_start, bus.gen_reset, bus.req_ready, bus.gen_a}
                !== {5'b00001, 4'b0000, 32'd0}) begin
                n_bad++; $display("FAIL midrst_cycle%0d: got v%b l%b busy%b st%b greset%b rdy%b a%0d want all 0 greset1",
                    i, bus.resp_valid, bus.resp_last, bus.busy, bus.gen_start, bus.gen_reset, bus.req_ready, bus.gen_a);
            end
        end
        rst = 1'b0; bus.gen_valid = 1'b0;
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0001) begin
            n_bad++; $display("FAIL midrst_grant0: got %b want 0001", bus.req_ready);
        end
        tick();
        n_cmp++;
        if ({bus.resp_valid, bus.resp_last} !== 2'b00) begin
            n_bad++; $display("FAIL midrst_no_last: got %b want 00", {bus.resp_valid, bus.resp_last});
        end
        bus.req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_coincident_done();
        test_fairness();
        test_wrap();
        test_timeout();
        test_reset_mid_job();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end
endmodule
